// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory port arbiter
// Purpose: FSM state encoding, access-owner encoding, starvation-streak width and the
//   default STARVE_LIMIT used by mem_port_arbiter and arb_pick.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Streak counter width; STARVE_LIMIT must fit in it (<= 255).
  localparam int STREAK_W         = 8;
  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational tie-break between fetch and data requests
// Purpose: decides whether an IDLE-cycle request is granted and which port wins.
// Ports:
//   if_req     in   fetch request level
//   dm_req     in   data request level
//   dm_streak  in   consecutive contended data grants so far
//   grant      out  some port is requesting
//   pick_dm    out  1 = data port wins, 0 = fetch port wins
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STREAK_W-1:0] dm_streak,
  output logic                grant,
  output logic                pick_dm
);

  assign grant = if_req | dm_req;

  // Data wins ties until it has won STARVE_LIMIT contended grants in a row;
  // with STARVE_LIMIT = 0 the streak always equals the limit, so fetch wins every tie.
  assign pick_dm = dm_req & (~if_req | (dm_streak != STREAK_W'(STARVE_LIMIT)));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between fetch and data ports
// Purpose: arbitrates the fetch (read-only) and data (read/write) ports onto a single memory
//   request/acknowledge interface, returns registered read data and per-port stalls.
// Optional feature: define MEM_ARB_PERF_CNT_EN to add grant/conflict performance counters.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   if_req_i/if_addr_i                  fetch request, address (held until if_ack_o)
//   if_ack_o/if_rdata_o                 fetch done pulse, fetched word (registered)
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request, write enable, address, store data
//   dm_ack_o/dm_rdata_o                 data done pulse, load data (registered)
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request (held until mem_ack_i)
//   mem_ack_i/mem_rdata_i               memory done, read data
//   if_stall_o/dm_stall_o               per-port stall to pipeline
//   perf_if_grant_o/perf_dm_grant_o/perf_conflict_o  counters (MEM_ARB_PERF_CNT_EN only)
//   busy_o                              arbiter not idle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_ack_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          if_stall_o,
  output logic          dm_stall_o,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [31:0]   perf_if_grant_o,
  output logic [31:0]   perf_dm_grant_o,
  output logic [31:0]   perf_conflict_o,
`endif
  output logic          busy_o
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                we_q, we_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       if_rdata_q, if_rdata_d;
  logic [DW-1:0]       dm_rdata_q, dm_rdata_d;
  logic                grant;
  logic                pick_dm;

  arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .if_req    (if_req_i),
    .dm_req    (dm_req_i),
    .dm_streak (streak_q),
    .grant     (grant),
    .pick_dm   (pick_dm)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          if (pick_dm) begin
            owner_d = OWN_DM;
            addr_d  = dm_addr_i;
            we_d    = dm_we_i;
            wdata_d = dm_wdata_i;
            // Only a data grant that made fetch wait extends the streak.
            if (!if_req_i)
              streak_d = '0;
            else if (streak_q != STREAK_W'(STARVE_LIMIT))
              streak_d = streak_q + 1'b1;
          end else begin
            owner_d  = OWN_IF;
            addr_d   = if_addr_i;
            we_d     = 1'b0;
            wdata_d  = '0;
            streak_d = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_ack_i) begin
          state_d = RESP;
          if (owner_q == OWN_IF)
            if_rdata_d = mem_rdata_i;
          else if (!we_q)
            dm_rdata_d = mem_rdata_i;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      streak_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == ISSUE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ack_o    = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_ack_o    = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_stall_o  = if_req_i & ~if_ack_o;
  assign dm_stall_o  = dm_req_i & ~dm_ack_o;
  assign busy_o      = (state_q != IDLE);

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_dm_q, perf_cf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
      perf_cf_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant && pick_dm)  perf_dm_q <= perf_dm_q + 32'd1;
      if (grant && !pick_dm) perf_if_q <= perf_if_q + 32'd1;
      if (if_req_i && dm_req_i) perf_cf_q <= perf_cf_q + 32'd1;
    end
  end

  assign perf_if_grant_o = perf_if_q;
  assign perf_dm_grant_o = perf_dm_q;
  assign perf_conflict_o = perf_cf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Purpose: directed sequences, a table of arbitration rounds and randomized traffic
//   against a transaction-level reference model. MEM_ARB_PERF_CNT_EN enables counter checks.
// Ports: none (top-level bench).
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        if_stall_o;
  logic        dm_stall_o;
  logic        busy_o;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_grant_o, perf_dm_grant_o, perf_conflict_o;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_mode = 0;   // 0: fixed-latency responder, 1: random responder, 2: bench drives by hand
  int mem_lat = 0;    // extra ISSUE cycles before ack in mode 0
  int wcnt = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_dm_rd = '0;

  // transaction-level reference model state
  bit          acc_active;
  int          acc_owner;   // 0 fetch, 1 data
  logic [31:0] acc_addr, acc_wdata;
  bit          acc_we;
  int          resp_cyc;
  int          m_streak;
  bit          take_dm, exp_mreq, exp_ia, exp_da;
  logic [31:0] ref_if, ref_dm;

  typedef struct {
    bit ir;
    bit dr;
    bit exp_dm;
    int lat;
  } row_t;
  row_t tbl [14];

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .if_req_i        (if_req_i),
    .if_addr_i       (if_addr_i),
    .if_ack_o        (if_ack_o),
    .if_rdata_o      (if_rdata_o),
    .dm_req_i        (dm_req_i),
    .dm_we_i         (dm_we_i),
    .dm_addr_i       (dm_addr_i),
    .dm_wdata_i      (dm_wdata_i),
    .dm_ack_o        (dm_ack_o),
    .dm_rdata_o      (dm_rdata_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rdata_i     (mem_rdata_i),
    .if_stall_o      (if_stall_o),
    .dm_stall_o      (dm_stall_o),
`ifdef MEM_ARB_PERF_CNT_EN
    .perf_if_grant_o (perf_if_grant_o),
    .perf_dm_grant_o (perf_dm_grant_o),
    .perf_conflict_o (perf_conflict_o),
`endif
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [159:0] all_outs();
    return {if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, mem_req_o, mem_we_o,
            mem_addr_o, mem_wdata_o, if_stall_o, dm_stall_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, sample point is 1 time unit after the rising edge; the memory
  // responder decides mem_ack_i/mem_rdata_i for the next edge here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_mode == 0) begin
      if (mem_req_o) begin
        if (wcnt == mem_lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          if (mem_we_o) ref_mem[mem_addr_o] = mem_wdata_o;
          wcnt = 0;
        end else begin
          mem_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack_i = 1'b0;
        wcnt = 0;
      end
    end else if (mem_mode == 1) begin
      mem_rdata_i = $urandom;
      if (mem_req_o) mem_ack_i = ($urandom_range(0, 2) == 0);
      else           mem_ack_i = ($urandom_range(0, 3) == 0);
    end
  endtask

  // One arbitration round: raise the requested ports, wait for the first ack, check winner,
  // latency in cycles from stimulus to ack, and read data.
  task automatic run_row(input bit ir, input bit dr, input bit exp_dm, input int exp_lat, input int row);
    int n;
    bit got;
    if_req_i  = ir;
    if_addr_i = 32'h100 + 32'(row * 8);
    dm_req_i  = dr;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h200 + 32'(row * 8);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (if_ack_o || dm_ack_o) got = 1'b1;
    end
    chk($sformatf("row%0d_ack_seen", row), got, 1);
    chk($sformatf("row%0d_winner", row), {if_ack_o, dm_ack_o}, exp_dm ? 2'b01 : 2'b10);
    chk($sformatf("row%0d_latency", row), n, exp_lat);
    if (exp_dm) exp_dm_rd = mem_word(dm_addr_i);
    else        exp_if_rd = mem_word(if_addr_i);
    chk($sformatf("row%0d_rdata", row), {if_rdata_o, dm_rdata_o}, {exp_if_rd, exp_dm_rd});
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 2};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 3};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 3};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 3};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 3};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 3};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 3};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 3};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 3};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 3};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 3};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 3};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 3};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3};

    // reset state
    rst_i = 1'b1;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 160'd0);
    rst_i = 1'b0;
    tick();
    chk("idle_outputs", all_outs(), 160'd0);

    // lone fetch, zero-wait memory
    mem_lat   = 0;
    if_addr_i = 32'h10;
    if_req_i  = 1'b1;
    #1;
    chk("t1_stall_pre", if_stall_o, 1);
    tick();
    chk("t1_issue", {mem_req_o, mem_we_o, mem_addr_o, if_ack_o, if_stall_o, busy_o},
        {1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 1'b1});
    tick();
    exp_if_rd = mem_word(32'h10);
    chk("t1_ack", {if_ack_o, if_stall_o, if_rdata_o}, {1'b1, 1'b0, exp_if_rd});
    if_req_i = 1'b0;
    tick();
    chk("t1_after", {if_ack_o, busy_o, if_rdata_o}, {1'b0, 1'b0, exp_if_rd});

    // arbitration and starvation rounds
    for (int i = 0; i < 14; i++) run_row(tbl[i].ir, tbl[i].dr, tbl[i].exp_dm, tbl[i].lat, i);
    tick();

    // data write with 3 ISSUE cycles
    mem_lat    = 2;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h40;
    dm_wdata_i = 32'hDEADBEEF;
    dm_req_i   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_issue", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dm_ack_o, dm_stall_o},
          {1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1});
    end
    tick();
    chk("t4_ack", {dm_ack_o, dm_stall_o, dm_rdata_o}, {1'b1, 1'b0, exp_dm_rd});
    dm_req_i = 1'b0;
    dm_we_i  = 1'b0;
    tick();
    chk("t4_done", {dm_ack_o, busy_o, dm_rdata_o}, {1'b0, 1'b0, exp_dm_rd});

    // reset during ISSUE, then a late memory ack
    mem_lat   = 50;
    dm_addr_i = 32'h44;
    dm_req_i  = 1'b1;
    tick();
    tick();
    chk("t5_issue", {mem_req_o, mem_addr_o}, {1'b1, 32'h44});
    rst_i    = 1'b1;
    dm_req_i = 1'b0;
    tick();
    chk("t5_reset", all_outs(), 160'd0);
    rst_i       = 1'b0;
    mem_mode    = 2;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_late_ack", all_outs(), 160'd0);
    end
    mem_ack_i = 1'b0;
    mem_mode  = 0;
    mem_lat   = 0;
    exp_if_rd = '0;
    exp_dm_rd = '0;

    // randomized traffic against the reference model
    acc_active = 1'b0;
    acc_owner  = 0;
    acc_addr   = '0;
    acc_wdata  = '0;
    acc_we     = 1'b0;
    resp_cyc   = -1;
    m_streak   = 0;
    ref_if     = '0;
    ref_dm     = '0;
    mem_mode   = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      exp_mreq = acc_active && (resp_cyc < 0);
      exp_ia   = acc_active && (resp_cyc == cyc) && (acc_owner == 0);
      exp_da   = acc_active && (resp_cyc == cyc) && (acc_owner == 1);
      chk("rnd_ctrl", {busy_o, mem_req_o, if_ack_o, dm_ack_o, if_stall_o, dm_stall_o},
          {acc_active, exp_mreq, exp_ia, exp_da, if_req_i & ~exp_ia, dm_req_i & ~exp_da});
      if (exp_mreq)
        chk("rnd_mem", {mem_addr_o, mem_we_o, acc_we ? mem_wdata_o : 32'h0},
            {acc_addr, acc_we, acc_we ? acc_wdata : 32'h0});
      chk("rnd_rdata", {if_rdata_o, dm_rdata_o}, {ref_if, ref_dm});
      // requesters may change only when idle or on their own ack
      if (!if_req_i || exp_ia) begin
        if_req_i  = ($urandom_range(0, 1) == 1);
        if_addr_i = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!dm_req_i || exp_da) begin
        dm_req_i   = ($urandom_range(0, 1) == 1);
        dm_we_i    = ($urandom_range(0, 2) == 0);
        dm_addr_i  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        dm_wdata_i = $urandom;
      end
      // what the arbiter must do at the coming edge
      if (acc_active) begin
        if (resp_cyc == cyc) begin
          acc_active = 1'b0;
        end else if (mem_ack_i) begin
          resp_cyc = cyc + 1;
          if (acc_owner == 0) ref_if = mem_rdata_i;
          else if (!acc_we)   ref_dm = mem_rdata_i;
        end
      end else if (if_req_i || dm_req_i) begin
        take_dm = dm_req_i && !(if_req_i && m_streak == LIMIT);
        if (take_dm) begin
          m_streak  = if_req_i ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
          acc_owner = 1;
          acc_addr  = dm_addr_i;
          acc_we    = dm_we_i;
          acc_wdata = dm_wdata_i;
        end else begin
          m_streak  = 0;
          acc_owner = 0;
          acc_addr  = if_addr_i;
          acc_we    = 1'b0;
          acc_wdata = '0;
        end
        acc_active = 1'b1;
        resp_cyc   = -1;
      end
    end
    if_req_i  = 1'b0;
    dm_req_i  = 1'b0;
    dm_we_i   = 1'b0;
    mem_mode  = 0;
    mem_ack_i = 1'b0;

`ifdef MEM_ARB_PERF_CNT_EN
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk("perf_reset", {perf_if_grant_o, perf_dm_grant_o, perf_conflict_o}, 96'd0);
    exp_if_rd = '0;
    exp_dm_rd = '0;
    run_row(1'b1, 1'b1, 1'b1, 2, 20);
    run_row(1'b1, 1'b1, 1'b1, 3, 21);
    run_row(1'b1, 1'b1, 1'b1, 3, 22);
    for (int k = 0; k < 5; k++) run_row(1'b1, 1'b0, 1'b0, 3, 23 + k);
    run_row(1'b0, 1'b1, 1'b1, 3, 28);
    run_row(1'b0, 1'b1, 1'b1, 3, 29);
    tick();
    chk("perf_counts", {perf_if_grant_o, perf_dm_grant_o, perf_conflict_o},
        {32'd5, 32'd5, 32'd3});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
